// File: rtl/imem_port_arbiter_if.sv
// Bus bundle between the fetch path, the program loader, the arbiter and the
// instruction-memory BRAM. The slave view is the arbiter and the master view is the requester/BRAM side.
interface imem_port_arbiter_if #(
    parameter int ADDR_W = 12
);
    logic              f_req;
    logic [31:0]       f_addr;
    logic              f_gnt;
    logic              f_rvalid;
    logic [31:0]       f_rdata;

    logic              l_req;
    logic              l_we;
    logic [31:0]       l_addr;
    logic [31:0]       l_wdata;
    logic              l_lock;
    logic              l_gnt;
    logic              l_rvalid;
    logic [31:0]       l_rdata;

    logic              core_hold;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  f_req, f_addr,
        output f_gnt, f_rvalid, f_rdata,
        input  l_req, l_we, l_addr, l_wdata, l_lock,
        output l_gnt, l_rvalid, l_rdata,
        output core_hold,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output f_req, f_addr,
        input  f_gnt, f_rvalid, f_rdata,
        output l_req, l_we, l_addr, l_wdata, l_lock,
        input  l_gnt, l_rvalid, l_rdata,
        input  core_hold,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/imem_port_arbiter.sv
// Shares the single instruction-memory BRAM port between fetch and the program loader.
// Optional grant/conflict counters are enabled with IMEM_ARB_PERF_EN.
//
// state   | meaning
// RUN     | fetch and loader reads arbitrated, loader writes refused
// DRAIN   | core held, no grants, lets the last read retire
// LOAD    | core held, loader owns the port for reads and writes
// RELEASE | core held, no grants, last loader read returns
module imem_port_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    imem_port_arbiter_if.slave   bus
`ifdef IMEM_ARB_PERF_EN
    ,
    output logic [31:0]          perf_fetch_grants,
    output logic [31:0]          perf_loader_grants,
    output logic [31:0]          perf_conflicts
`endif
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        LOAD    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t            state;
    state_t            state_nxt;
    logic              f_gnt_c;
    logic              l_gnt_c;
    logic              hold_c;
    logic              f_gnt;
    logic              l_gnt;
    logic              l_rd;
    logic              fetch_forced;
    logic [3:0]        starve_cnt;
    logic              f_tag;
    logic              l_tag;
    logic [ADDR_W-1:0] f_word;
    logic [ADDR_W-1:0] l_word;
    logic              unused_addr_bits;

    assign f_word = bus.f_addr[ADDR_W+1:2];
    assign l_word = bus.l_addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{bus.f_addr[31:ADDR_W+2], bus.f_addr[1:0],
                                bus.l_addr[31:ADDR_W+2], bus.l_addr[1:0]};

    assign l_rd         = bus.l_req && !bus.l_we;
    assign fetch_forced = (starve_cnt == STARVE_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        f_gnt_c   = 1'b0;
        l_gnt_c   = 1'b0;
        hold_c    = 1'b0;
        case (state)
            RUN: begin
                f_gnt_c = bus.f_req && (!l_rd || fetch_forced);
                l_gnt_c = l_rd && !(bus.f_req && fetch_forced);
                if (bus.l_lock) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                hold_c    = 1'b1;
                state_nxt = LOAD;
            end
            LOAD: begin
                hold_c = 1'b1;
                // Dropping the lock wins over a same-cycle loader request.
                if (bus.l_lock) begin
                    l_gnt_c = bus.l_req;
                end else begin
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                hold_c    = 1'b1;
                state_nxt = RUN;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    assign f_gnt         = f_gnt_c && !rst;
    assign l_gnt         = l_gnt_c && !rst;
    assign bus.f_gnt     = f_gnt;
    assign bus.l_gnt     = l_gnt;
    assign bus.core_hold = hold_c && !rst;

    assign bus.mem_en    = f_gnt || l_gnt;
    assign bus.mem_we    = l_gnt && bus.l_we;
    assign bus.mem_addr  = l_gnt ? l_word : f_word;
    assign bus.mem_wdata = bus.l_wdata;

    // Held at zero outside RUN so the count restarts cleanly on re-entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= 4'd0;
        end else if (state != RUN) begin
            starve_cnt <= 4'd0;
        end else if (f_gnt) begin
            starve_cnt <= 4'd0;
        end else if (bus.f_req && (starve_cnt != STARVE_MAX)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            f_tag <= 1'b0;
            l_tag <= 1'b0;
        end else begin
            f_tag <= f_gnt;
            l_tag <= l_gnt && !bus.l_we;
        end
    end

    // Reset also masks a read returning in the reset cycle itself.
    assign bus.f_rvalid = f_tag && !rst;
    assign bus.l_rvalid = l_tag && !rst;
    assign bus.f_rdata  = bus.mem_rdata;
    assign bus.l_rdata  = bus.mem_rdata;

`ifdef IMEM_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_grants  <= 32'd0;
            perf_loader_grants <= 32'd0;
            perf_conflicts     <= 32'd0;
        end else begin
            if (f_gnt) begin
                perf_fetch_grants <= perf_fetch_grants + 32'd1;
            end
            if (l_gnt) begin
                perf_loader_grants <= perf_loader_grants + 32'd1;
            end
            if ((state == RUN) && bus.f_req && l_rd) begin
                perf_conflicts <= perf_conflicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a 1-cycle-latency BRAM model.
// Word i of the model memory initially holds the value i.
module tb_imem_port_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    logic [31:0] mem [0:4095];

    imem_port_arbiter_if #(.ADDR_W(12)) bus ();

    imem_port_arbiter #(.ADDR_W(12), .STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.f_req = 1'b1; bus.l_req = 1'b1; bus.l_we = 1'b0;
        @(negedge clk);
        checks++; if (bus.f_gnt !== 1'b0) begin failures++; $display("FAIL rst_f_gnt got=%b exp=0", bus.f_gnt); end
        checks++; if (bus.l_gnt !== 1'b0) begin failures++; $display("FAIL rst_l_gnt got=%b exp=0", bus.l_gnt); end
        checks++; if (bus.mem_en !== 1'b0) begin failures++; $display("FAIL rst_mem_en got=%b exp=0", bus.mem_en); end
        checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we got=%b exp=0", bus.mem_we); end
        next_cycle();
        next_cycle();
        bus.f_req = 1'b0; bus.l_req = 1'b0; rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.f_rvalid !== 1'b0) begin failures++; $display("FAIL rst_f_rvalid got=%b exp=0", bus.f_rvalid); end
        checks++; if (bus.l_rvalid !== 1'b0) begin failures++; $display("FAIL rst_l_rvalid got=%b exp=0", bus.l_rvalid); end
        checks++; if (bus.core_hold !== 1'b0) begin failures++; $display("FAIL rst_core_hold got=%b exp=0", bus.core_hold); end
        next_cycle();
    endtask

    task automatic test_fetch_only();
        for (int k = 0; k < 4; k++) begin
            bus.f_req  = (k < 3);
            bus.f_addr = 32'(4 * k);
            @(negedge clk);
            checks++; if (bus.f_gnt !== (k < 3)) begin failures++; $display("FAIL fetch_gnt k=%0d got=%b exp=%b", k, bus.f_gnt, (k < 3)); end
            if (k < 3) begin
                checks++; if (bus.mem_addr !== 12'(k)) begin failures++; $display("FAIL fetch_mem_addr k=%0d got=%0d exp=%0d", k, bus.mem_addr, k); end
            end
            checks++; if (bus.f_rvalid !== (k > 0)) begin failures++; $display("FAIL fetch_rvalid k=%0d got=%b exp=%b", k, bus.f_rvalid, (k > 0)); end
            if (k > 0) begin
                checks++; if (bus.f_rdata !== 32'(k - 1)) begin failures++; $display("FAIL fetch_rdata k=%0d got=%0h exp=%0h", k, bus.f_rdata, k - 1); end
            end
            checks++; if (bus.l_rvalid !== 1'b0) begin failures++; $display("FAIL fetch_l_rvalid k=%0d got=%b exp=0", k, bus.l_rvalid); end
            next_cycle();
        end
    endtask

    task automatic test_contention();
        logic exp_f;
        logic prev_f;
        prev_f = 1'b0;
        bus.f_addr = 32'h80;   // word 32
        bus.l_addr = 32'h40;   // word 16
        bus.l_we   = 1'b0;
        for (int i = 0; i < 11; i++) begin
            bus.f_req = (i < 10);
            bus.l_req = (i < 10);
            exp_f = (i == 4) || (i == 9);
            @(negedge clk);
            if (i < 10) begin
                checks++; if (bus.f_gnt !== exp_f) begin failures++; $display("FAIL cont_f_gnt i=%0d got=%b exp=%b", i, bus.f_gnt, exp_f); end
                checks++; if (bus.l_gnt !== !exp_f) begin failures++; $display("FAIL cont_l_gnt i=%0d got=%b exp=%b", i, bus.l_gnt, !exp_f); end
                checks++; if (bus.mem_addr !== (exp_f ? 12'd32 : 12'd16)) begin failures++; $display("FAIL cont_mem_addr i=%0d got=%0d", i, bus.mem_addr); end
            end
            if (i > 0) begin
                checks++; if (bus.f_rvalid !== prev_f) begin failures++; $display("FAIL cont_f_rvalid i=%0d got=%b exp=%b", i, bus.f_rvalid, prev_f); end
                checks++; if (bus.l_rvalid !== !prev_f) begin failures++; $display("FAIL cont_l_rvalid i=%0d got=%b exp=%b", i, bus.l_rvalid, !prev_f); end
                if (prev_f) begin
                    checks++; if (bus.f_rdata !== 32'd32) begin failures++; $display("FAIL cont_f_rdata i=%0d got=%0h exp=20", i, bus.f_rdata); end
                end else begin
                    checks++; if (bus.l_rdata !== 32'd16) begin failures++; $display("FAIL cont_l_rdata i=%0d got=%0h exp=10", i, bus.l_rdata); end
                end
            end
            prev_f = exp_f;
            next_cycle();
        end
    endtask

    task automatic test_write_in_run();
        bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_lock = 1'b0;
        bus.l_addr = 32'h20; bus.l_wdata = 32'h1234_5678;
        bus.f_req = 1'b1; bus.f_addr = 32'h8;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (bus.l_gnt !== 1'b0) begin failures++; $display("FAIL wrun_l_gnt i=%0d got=%b exp=0", i, bus.l_gnt); end
            checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL wrun_mem_we i=%0d got=%b exp=0", i, bus.mem_we); end
            checks++; if (bus.f_gnt !== 1'b1) begin failures++; $display("FAIL wrun_f_gnt i=%0d got=%b exp=1", i, bus.f_gnt); end
            if (i > 0) begin
                checks++; if (bus.f_rdata !== 32'd2) begin failures++; $display("FAIL wrun_f_rdata i=%0d got=%0h exp=2", i, bus.f_rdata); end
            end
            next_cycle();
        end
        bus.l_req = 1'b0; bus.l_we = 1'b0; bus.f_req = 1'b0;
        next_cycle();
    endtask

    task automatic test_program_mode();
        bus.l_lock = 1'b1; bus.f_req = 1'b1; bus.f_addr = 32'h0;
        @(negedge clk);
        checks++; if (bus.f_gnt !== 1'b1) begin failures++; $display("FAIL pm_lock_f_gnt got=%b exp=1", bus.f_gnt); end
        checks++; if (bus.core_hold !== 1'b0) begin failures++; $display("FAIL pm_lock_hold got=%b exp=0", bus.core_hold); end
        next_cycle();
        bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 32'h10; bus.l_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++; if (bus.f_gnt !== 1'b0) begin failures++; $display("FAIL pm_drain_f_gnt got=%b exp=0", bus.f_gnt); end
        checks++; if (bus.l_gnt !== 1'b0) begin failures++; $display("FAIL pm_drain_l_gnt got=%b exp=0", bus.l_gnt); end
        checks++; if (bus.core_hold !== 1'b1) begin failures++; $display("FAIL pm_drain_hold got=%b exp=1", bus.core_hold); end
        checks++; if (bus.f_rvalid !== 1'b1) begin failures++; $display("FAIL pm_drain_f_rvalid got=%b exp=1", bus.f_rvalid); end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.l_gnt !== 1'b1) begin failures++; $display("FAIL pm_wr_l_gnt got=%b exp=1", bus.l_gnt); end
        checks++; if (bus.mem_we !== 1'b1) begin failures++; $display("FAIL pm_wr_mem_we got=%b exp=1", bus.mem_we); end
        checks++; if (bus.mem_addr !== 12'd4) begin failures++; $display("FAIL pm_wr_mem_addr got=%0d exp=4", bus.mem_addr); end
        checks++; if (bus.f_gnt !== 1'b0) begin failures++; $display("FAIL pm_wr_f_gnt got=%b exp=0", bus.f_gnt); end
        next_cycle();
        bus.l_we = 1'b0;
        @(negedge clk);
        checks++; if (bus.l_gnt !== 1'b1) begin failures++; $display("FAIL pm_rd_l_gnt got=%b exp=1", bus.l_gnt); end
        checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL pm_rd_mem_we got=%b exp=0", bus.mem_we); end
        checks++; if (bus.l_rvalid !== 1'b0) begin failures++; $display("FAIL pm_wr_no_rvalid got=%b exp=0", bus.l_rvalid); end
        next_cycle();
        bus.l_req = 1'b0;
        @(negedge clk);
        checks++; if (bus.l_rvalid !== 1'b1) begin failures++; $display("FAIL pm_l_rvalid got=%b exp=1", bus.l_rvalid); end
        checks++; if (bus.l_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL pm_l_rdata got=%0h exp=deadbeef", bus.l_rdata); end
        checks++; if (bus.f_gnt !== 1'b0) begin failures++; $display("FAIL pm_end_f_gnt got=%b exp=0", bus.f_gnt); end
        checks++; if (bus.core_hold !== 1'b1) begin failures++; $display("FAIL pm_end_hold got=%b exp=1", bus.core_hold); end
        next_cycle();
    endtask

    task automatic test_exit();
        bus.l_lock = 1'b0; bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = 32'h10;
        @(negedge clk);
        checks++; if (bus.l_gnt !== 1'b0) begin failures++; $display("FAIL exit_l_gnt got=%b exp=0", bus.l_gnt); end
        checks++; if (bus.core_hold !== 1'b1) begin failures++; $display("FAIL exit_hold got=%b exp=1", bus.core_hold); end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.l_gnt !== 1'b0) begin failures++; $display("FAIL rel_l_gnt got=%b exp=0", bus.l_gnt); end
        checks++; if (bus.f_gnt !== 1'b0) begin failures++; $display("FAIL rel_f_gnt got=%b exp=0", bus.f_gnt); end
        checks++; if (bus.core_hold !== 1'b1) begin failures++; $display("FAIL rel_hold got=%b exp=1", bus.core_hold); end
        next_cycle();
        bus.l_req = 1'b0; bus.f_addr = 32'h10;
        @(negedge clk);
        checks++; if (bus.core_hold !== 1'b0) begin failures++; $display("FAIL run_hold got=%b exp=0", bus.core_hold); end
        checks++; if (bus.f_gnt !== 1'b1) begin failures++; $display("FAIL run_f_gnt got=%b exp=1", bus.f_gnt); end
        next_cycle();
        bus.f_req = 1'b0;
        @(negedge clk);
        checks++; if (bus.f_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL run_f_rdata got=%0h exp=deadbeef", bus.f_rdata); end
        next_cycle();
    endtask

    task automatic test_reset_mid_read();
        bus.f_req = 1'b1; bus.f_addr = 32'hC;
        @(negedge clk);
        checks++; if (bus.f_gnt !== 1'b1) begin failures++; $display("FAIL mrst_f_gnt got=%b exp=1", bus.f_gnt); end
        next_cycle();
        rst = 1'b1; bus.l_req = 1'b1;
        @(negedge clk);
        checks++; if (bus.f_rvalid !== 1'b0) begin failures++; $display("FAIL mrst_f_rvalid got=%b exp=0", bus.f_rvalid); end
        checks++; if (bus.f_gnt !== 1'b0) begin failures++; $display("FAIL mrst_gnt_f got=%b exp=0", bus.f_gnt); end
        checks++; if (bus.l_gnt !== 1'b0) begin failures++; $display("FAIL mrst_gnt_l got=%b exp=0", bus.l_gnt); end
        checks++; if (bus.mem_en !== 1'b0) begin failures++; $display("FAIL mrst_mem_en got=%b exp=0", bus.mem_en); end
        next_cycle();
        rst = 1'b0; bus.f_req = 1'b0; bus.l_req = 1'b0;
        @(negedge clk);
        checks++; if (bus.f_rvalid !== 1'b0) begin failures++; $display("FAIL mrst_after_rvalid got=%b exp=0", bus.f_rvalid); end
        next_cycle();
        bus.l_lock = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++; if (bus.core_hold !== 1'b1) begin failures++; $display("FAIL lrst_load_hold got=%b exp=1", bus.core_hold); end
        next_cycle();
        rst = 1'b1; bus.l_lock = 1'b0;
        next_cycle();
        rst = 1'b0; bus.f_req = 1'b1; bus.f_addr = 32'hFFFF_C00B;
        @(negedge clk);
        checks++; if (bus.core_hold !== 1'b0) begin failures++; $display("FAIL lrst_hold got=%b exp=0", bus.core_hold); end
        checks++; if (bus.f_gnt !== 1'b1) begin failures++; $display("FAIL lrst_f_gnt got=%b exp=1", bus.f_gnt); end
        checks++; if (bus.mem_addr !== 12'd2) begin failures++; $display("FAIL wrap_mem_addr got=%0d exp=2", bus.mem_addr); end
        next_cycle();
        bus.f_req = 1'b0;
        @(negedge clk);
        checks++; if (bus.f_rdata !== 32'd2) begin failures++; $display("FAIL wrap_f_rdata got=%0h exp=2", bus.f_rdata); end
        next_cycle();
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'(i);
        checks = 0; failures = 0;
        rst = 1'b1;
        bus.f_req = 1'b0; bus.f_addr = 32'h0;
        bus.l_req = 1'b0; bus.l_we = 1'b0; bus.l_addr = 32'h0;
        bus.l_wdata = 32'h0; bus.l_lock = 1'b0;
        bus.mem_rdata = 32'h0;
        test_reset();
        test_fetch_only();
        test_contention();
        test_write_in_run();
        test_program_mode();
        test_exit();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
